// File: rtl/mul_acc_unit_pkg.sv
// Shared multiply/accumulate definitions: FSM states, function codes and
// small operand helpers used by the multiply/accumulate unit.
package mul_acc_unit_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_e;

  typedef enum logic [5:0] {
    MUL   = 6'h02,
    MFHI  = 6'h10,
    MTHI  = 6'h11,
    MFLO  = 6'h12,
    MTLO  = 6'h13,
    MULT  = 6'h18,
    MULTU = 6'h19,
    MADD  = 6'h1C,
    MADDU = 6'h1D,
    MSUB  = 6'h1E,
    MSUBU = 6'h1F,
    CLZ   = 6'h20,
    CLO   = 6'h21
  } func_e;

  // True for the operations that treat A and B as two's-complement values.
  function automatic logic is_signed_op(input func_e f);
    case (f)
      MULT, MADD, MSUB, MUL: return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

  // Magnitude of an operand; 0x80000000 maps to 2^31 as an unsigned value.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x,
                                                  input logic sgn);
    if (sgn && x[DATA_W-1]) begin
      return 32'd0 - x;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/mul_acc_unit_lead_count.sv
// Combinational leading-zero / leading-one counter (result 0..32).
module lead_count
  import mul_acc_unit_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic              ones_i,
  output logic [5:0]        count_o
);

  logic [DATA_W-1:0] scan_s;
  logic              found_s;
  logic [5:0]        count_s;

  // Counting leading ones is counting leading zeros of the inverted word.
  always_comb begin
    scan_s  = ones_i ? ~data_i : data_i;
    found_s = 1'b0;
    count_s = 6'd32;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (!found_s && scan_s[i]) begin
        found_s = 1'b1;
        count_s = 6'd31 - 6'(i);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign count_o = count_s;

endmodule

// File: rtl/mul_acc_unit.sv
// Multi-cycle multiply/accumulate unit with HI/LO accumulator.
// Multiplies run as a sign-magnitude shift-add loop (one magnitude-setup
// cycle plus 32 steps); all other functions finish one cycle after accept.
module mul_acc_unit
  import mul_acc_unit_pkg::*;
(
  input  logic              Clock,
  input  logic              nReset,
  input  logic              Start,
  input  logic [5:0]        Func,
  input  logic              MULSelB,
  input  logic              ACCEn,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              Flush,
  output logic              Ready,
  output logic              Done,
  output logic [DATA_W-1:0] Result,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        init_q, init_d;
  func_e       func_q, func_d;
  logic        acc_en_q, acc_en_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        neg_q, neg_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  logic        sgn_s;
  logic [63:0] prod_fin_s;
  logic [63:0] acc_s;
  logic [63:0] acc_new_s;
  logic [5:0]  lead_cnt_s;

  lead_count u_lead_count (
    .data_i  (a_q),
    .ones_i  (func_q == CLO),
    .count_o (lead_cnt_s)
  );

  // Next-state and multiplier datapath: accept, magnitude setup, shift-add steps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    init_d   = init_q;
    func_d   = func_q;
    acc_en_d = acc_en_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    sgn_s    = is_signed_op(func_q);
    if (Flush) begin
      state_d = IDLE;
      init_d  = 1'b0;
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            func_d   = func_e'(Func);
            acc_en_d = ACCEn;
            a_d      = A;
            b_d      = B;
            neg_d    = 1'b0;
            prod_d   = 64'd0;
            cnt_d    = 5'd0;
            if (MULSelB) begin
              state_d = CALC;
              init_d  = 1'b1;
            end else begin
              state_d = FINISH;
              init_d  = 1'b0;
            end
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          if (init_q) begin
            // Form magnitudes once so the step loop is purely unsigned.
            mcand_d  = {32'd0, magnitude(a_q, sgn_s)};
            mplier_d = magnitude(b_q, sgn_s);
            neg_d    = sgn_s & (a_q[31] ^ b_q[31]);
            init_d   = 1'b0;
          end else begin
            prod_d   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_d = FINISH;
            end else begin
              state_d = CALC;
            end
          end
        end
        FINISH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output process: apply the latched function in FINISH and pulse Done.
  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    result_d   = result_q;
    done_d     = 1'b0;
    prod_fin_s = neg_q ? (64'd0 - prod_q) : prod_q;
    acc_s      = {hi_q, lo_q};
    acc_new_s  = acc_s;
    if (!Flush && (state_q == FINISH)) begin
      done_d = 1'b1;
      case (func_q)
        MULT, MULTU: begin
          acc_new_s = prod_fin_s;
          result_d  = prod_fin_s[31:0];
        end
        MADD, MADDU: begin
          acc_new_s = acc_s + prod_fin_s;
          result_d  = acc_new_s[31:0];
        end
        MSUB, MSUBU: begin
          acc_new_s = acc_s - prod_fin_s;
          result_d  = acc_new_s[31:0];
        end
        MUL:      result_d = prod_fin_s[31:0];
        MTHI: begin
          acc_new_s = {a_q, lo_q};
          result_d  = 32'd0;
        end
        MTLO: begin
          acc_new_s = {hi_q, a_q};
          result_d  = 32'd0;
        end
        MFHI:     result_d = hi_q;
        MFLO:     result_d = lo_q;
        CLZ, CLO: result_d = {26'd0, lead_cnt_s};
        default:  result_d = 32'd0;
      endcase
      if (acc_en_q) begin
        hi_d = acc_new_s[63:32];
        lo_d = acc_new_s[31:0];
      end else begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    end else begin
      done_d = 1'b0;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      init_q   <= 1'b0;
      func_q   <= MUL;
      acc_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      init_q   <= init_d;
      func_q   <= func_d;
      acc_en_q <= acc_en_d;
      done_q   <= done_d;
    end
  end

  // Operand, product and architectural register state with asynchronous reset.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      neg_q    <= 1'b0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      prod_q   <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      result_q <= 32'd0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign Ready  = (state_q == IDLE);
  assign Done   = done_q;
  assign Result = result_q;
  assign HI     = hi_q;
  assign LO     = lo_q;

endmodule

// File: tb/tb_mul_acc_unit.sv
// Self-checking bench for mul_acc_unit: directed cases, randomized
// operations against an arithmetic reference model, flush and reset aborts.
module tb_mul_acc_unit;
  import mul_acc_unit_pkg::*;

  logic        Clock;
  logic        nReset;
  logic        Start;
  logic [5:0]  Func;
  logic        MULSelB;
  logic        ACCEn;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        Ready;
  logic        Done;
  logic [31:0] Result;
  logic [31:0] HI;
  logic [31:0] LO;

  int tests_run = 0;
  int fails     = 0;

  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;
  logic [31:0] res_m = 32'd0;

  mul_acc_unit dut (
    .Clock   (Clock),
    .nReset  (nReset),
    .Start   (Start),
    .Func    (Func),
    .MULSelB (MULSelB),
    .ACCEn   (ACCEn),
    .A       (A),
    .B       (B),
    .Flush   (Flush),
    .Ready   (Ready),
    .Done    (Done),
    .Result  (Result),
    .HI      (HI),
    .LO      (LO)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic uses_mul(input logic [5:0] f);
    return (f == MULT) || (f == MULTU) || (f == MADD) || (f == MADDU) ||
           (f == MSUB) || (f == MSUBU) || (f == MUL);
  endfunction

  function automatic logic writes_acc(input logic [5:0] f);
    return (f == MULT) || (f == MULTU) || (f == MADD) || (f == MADDU) ||
           (f == MSUB) || (f == MSUBU) || (f == MTHI) || (f == MTLO);
  endfunction

  function automatic logic [31:0] lead(input logic [31:0] v, input logic bitval);
    int n = 0;
    while (n < 32 && v[31-n] == bitval) n++;
    return 32'(n);
  endfunction

  // Reference: 64-bit products from native integer multiply, modulo 2^64.
  task automatic model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     ps, pu, acc;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ps  = sa * sb;
    pu  = ua * ub;
    acc = {hi_m, lo_m};
    case (f)
      MULT:  begin acc = ps;       res_m = acc[31:0]; end
      MULTU: begin acc = pu;       res_m = acc[31:0]; end
      MADD:  begin acc = acc + ps; res_m = acc[31:0]; end
      MADDU: begin acc = acc + pu; res_m = acc[31:0]; end
      MSUB:  begin acc = acc - ps; res_m = acc[31:0]; end
      MSUBU: begin acc = acc - pu; res_m = acc[31:0]; end
      MUL:   res_m = ps[31:0];
      MTHI:  begin acc[63:32] = a; res_m = 32'd0; end
      MTLO:  begin acc[31:0]  = a; res_m = 32'd0; end
      MFHI:  res_m = hi_m;
      MFLO:  res_m = lo_m;
      CLZ:   res_m = lead(a, 1'b0);
      CLO:   res_m = lead(a, 1'b1);
      default: res_m = 32'd0;
    endcase
    hi_m = acc[63:32];
    lo_m = acc[31:0];
  endtask

  task automatic accept_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (Ready !== 1'b1 && n < 100) begin
      @(posedge Clock); #1; n++;
    end
    check("ready_idle", 64'(Ready), 64'd1);
    Func = f; A = a; B = b;
    MULSelB = uses_mul(f);
    ACCEn = writes_acc(f);
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    check("ready_busy", 64'(Ready), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int cyc = 0;
    bit seen = 1'b0;
    accept_op(f, a, b);
    model_op(f, a, b);
    while (!seen && cyc < 60) begin
      @(posedge Clock); #1; cyc++;
      if (Done === 1'b1) seen = 1'b1;
    end
    check({tag, "_latency"}, 64'(cyc), uses_mul(f) ? 64'd34 : 64'd1);
    check({tag, "_result"}, 64'(Result), 64'(res_m));
    check({tag, "_hilo"}, {HI, LO}, {hi_m, lo_m});
    @(posedge Clock); #1;
    check({tag, "_done_pulse"}, 64'(Done), 64'd0);
    check({tag, "_ready_after"}, 64'(Ready), 64'd1);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge Clock); #1;
      if (Done === 1'b1) cnt++;
    end
  endtask

  logic [5:0]  ops [14];
  logic [31:0] corners [5];
  logic [5:0]  f_r;
  logic [31:0] a_r, b_r;
  int          dcnt;

  initial begin
    ops = '{MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MUL,
            MTHI, MTLO, MFHI, MFLO, CLZ, CLO, 6'h3F};
    corners = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001};
    nReset = 1'b0; Start = 1'b0; Func = 6'd0; MULSelB = 1'b0; ACCEn = 1'b0;
    A = 32'd0; B = 32'd0; Flush = 1'b0;

    // Reset state
    #1;
    check("rst_ready",  64'(Ready),  64'd1);
    check("rst_done",   64'(Done),   64'd0);
    check("rst_hilo",   {HI, LO},    64'd0);
    check("rst_result", 64'(Result), 64'd0);
    #20 nReset = 1'b1;
    @(posedge Clock); #1;

    // Directed cases
    run_op("mult_neg1x3", MULT, 32'hFFFF_FFFF, 32'h0000_0003);
    check("mult_neg1x3_hilo_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("maddu_2x3", MADDU, 32'd2, 32'd3);
    check("maddu_hilo_const", {HI, LO}, 64'hFFFF_FFFE_0000_0007);
    run_op("mthi_0", MTHI, 32'd0, 32'd0);
    run_op("mtlo_5", MTLO, 32'd5, 32'd0);
    run_op("msub_1x6", MSUB, 32'd1, 32'd6);
    check("msub_hilo_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mfhi", MFHI, 32'd0, 32'd0);
    check("mfhi_result_const", 64'(Result), 64'hFFFF_FFFF);
    run_op("clz_0", CLZ, 32'h0000_0000, 32'd0);
    check("clz_0_const", 64'(Result), 64'd32);
    run_op("clo_f0", CLO, 32'hF000_0000, 32'd0);
    check("clo_f0_const", 64'(Result), 64'd4);
    run_op("clz_msb", CLZ, 32'h8000_0000, 32'd0);
    check("clz_msb_const", 64'(Result), 64'd0);
    run_op("mult_minint", MULT, 32'h8000_0000, 32'h8000_0000);
    run_op("unknown", 6'h3F, 32'h1234_5678, 32'd9);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      f_r = ops[$urandom_range(0, 13)];
      a_r = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
      b_r = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
      run_op("rand", f_r, a_r, b_r);
    end

    // Flush mid-multiply; Start during CALC and with Flush is ignored
    accept_op(MULT, 32'h0001_0000, 32'h0000_0777);
    for (int k = 1; k < 10; k++) begin
      @(posedge Clock); #1;
      if (k == 4) begin
        Func = MTHI; A = 32'h0000_1234; MULSelB = 1'b0; ACCEn = 1'b1; Start = 1'b1;
      end
      if (k == 6) check("flush_ready_calc", 64'(Ready), 64'd0);
    end
    Flush = 1'b1;
    @(posedge Clock); #1;
    Flush = 1'b0; Start = 1'b0;
    check("flush_ready", 64'(Ready), 64'd1);
    count_done(40, dcnt);
    check("flush_no_done", 64'(dcnt), 64'd0);
    check("flush_hilo", {HI, LO}, {hi_m, lo_m});
    check("flush_ready_idle", 64'(Ready), 64'd1);

    // Asynchronous reset during a MADD
    accept_op(MADD, 32'h0000_0123, 32'h0000_0456);
    for (int k = 1; k < 20; k++) begin
      @(posedge Clock); #1;
    end
    @(posedge Clock); #2;
    nReset = 1'b0;
    #1;
    check("arst_hilo",   {HI, LO},    64'd0);
    check("arst_ready",  64'(Ready),  64'd1);
    check("arst_done",   64'(Done),   64'd0);
    check("arst_result", 64'(Result), 64'd0);
    hi_m = 32'd0; lo_m = 32'd0;
    #3 nReset = 1'b1;
    count_done(40, dcnt);
    check("arst_no_done", 64'(dcnt), 64'd0);
    run_op("post_rst_maddu", MADDU, 32'h0000_1000, 32'h0000_2000);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/mul_acc_unit.md
MUL_ACC_UNIT -- requirements
Module: mul_acc_unit

Interface
REQ-001 Clock  in  1  sole clock; all state updates on its rising edge.
REQ-002 nReset  in  1  asynchronous, active-low reset.
REQ-003 Start  in  1  request to begin an operation; accepted only when Ready=1.
REQ-004 Func  in  6  operation code from the shared MUL/ALU function definitions; sampled on accept.
REQ-005 MULSelB  in  1  operation uses multiplier (B operand); sampled on accept.
REQ-006 ACCEn  in  1  operation writes the HI/LO accumulator; sampled on accept.
REQ-007 A, B  in  32 each  operands; sampled on accept.
REQ-008 Flush  in  1  abort any in-flight operation.
REQ-009 Ready  out  1  unit is idle and able to accept Start.
REQ-010 Done  out  1  one-cycle pulse; Result is valid in that cycle.
REQ-011 Result  out  32  operation result, held until next Done.
REQ-012 HI, LO  out  32 each  architectural accumulator registers.

Function
REQ-013 Decided parameter: one clock; reset is asynchronous and active-low.
REQ-014 FSM states are IDLE, CALC and FINISH; Ready=1 only in IDLE.
REQ-015 IDLE with Start=1 and Flush=0: latch Func/A/B/flags; on MULSelB=1 go to CALC with a 5-bit counter of 0, else go to FINISH.
REQ-016 CALC: one shift-add step per cycle on 32-bit operand magnitudes; after step 31 (counter wraps to 0) go to FINISH.
REQ-017 Multiply latency: Done is asserted 34 cycles after the accept edge. Non-multiply latency: Done is asserted 1 cycle after the accept edge.
REQ-018 FINISH: apply the operation, pulse Done and return to IDLE. A Start arriving in the same cycle is not accepted.
REQ-019 Signed ops (MULT, MADD, MSUB, MUL): magnitudes are formed from two's-complement operands; the 64-bit product is negated when the operand signs differ. 0x80000000 is handled as magnitude 2^31.
REQ-020 MULT/MULTU: {HI,LO} = product; Result = product[31:0].
REQ-021 MADD/MADDU: {HI,LO} += product. MSUB/MSUBU: {HI,LO} -= product. All 64-bit arithmetic is modulo 2^64. Result = new LO.
REQ-022 MUL: Result = product[31:0]; HI/LO unchanged.
REQ-023 MTHI: HI = A. MTLO: LO = A. MFHI: Result = HI. MFLO: Result = LO. CLZ/CLO: Result = count of leading zeros/ones of A, in the range 0..32.
REQ-024 Unknown Func: Result = 0, HI/LO unchanged, Done still pulses.
REQ-025 Flush=1 in any state: go to IDLE next edge, no Done, HI/LO unchanged. Flush overrides a simultaneous Start.
REQ-026 Start while Ready=0 is ignored; the upstream stage stalls on Ready.

Reset
REQ-027 nReset low: state = IDLE, counter = 0, HI = LO = Result = 0, Done = 0, Ready = 1, immediately and independent of Clock.
REQ-028 Reset mid-operation discards the operation; no Done is produced.

Structure
REQ-029 The FSM state enum and the Func codes (MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MUL, MTHI, MTLO, MFHI, MFLO, CLZ, CLO) live in the shared mul definition package.
REQ-030 Leading-zero/one counting is one combinational sub-module, lead_count (32-bit in, 6-bit count out, mode select).

Verification
REQ-031 MULT A=0xFFFFFFFF, B=0x00000003 -> Done at accept+34, HI=0xFFFFFFFF, LO=0xFFFFFFFD.
REQ-032 MULTU A=B=0xFFFFFFFF, then MADDU A=2, B=3 -> HI=0xFFFFFFFE, LO=0x00000007.
REQ-033 MTLO A=5, then MSUB A=1, B=6 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF; MFHI -> Result=0xFFFFFFFF at accept+1.
REQ-034 CLZ A=0 -> Result=32; CLO A=0xF0000000 -> Result=4; CLZ A=0x80000000 -> Result=0.
REQ-035 MULT accepted, Flush at cycle 10 -> no Done, Ready=1 next cycle, HI/LO unchanged; Start during CALC is ignored.
REQ-036 nReset low at cycle 20 of a MADD -> HI=LO=0, Ready=1 asynchronously, no Done after release.
